// File: rtl/cdc_mcp_tx_fifo.sv
// First-word-fall-through FIFO that buffers a producer burst ahead of the MCP CDC sender.
// Optional statistics outputs are enabled by defining CDC_MCP_TX_FIFO_STATS_EN.
module cdc_mcp_tx_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                     i_aclk,
  input  logic                     i_arst_n,
  input  logic                     i_flush,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  output logic                     o_asend,
  output logic [DATA_WIDTH-1:0]    o_adata,
  input  logic                     i_aready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_afull
`ifdef CDC_MCP_TX_FIFO_STATS_EN
  ,
  input  logic                     i_stats_clr,
  output logic [31:0]              o_sent_count,
  output logic                     o_push_blocked
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] LVL_FULL  = PW'(DEPTH);
  localparam logic [PW-1:0] LVL_AFULL = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] ONE       = PW'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_level;
  logic                  w_push;
  logic                  w_pop;

  // Flags come from the registered level, so o_asend never sees i_aready combinationally.
  assign o_level  = r_level;
  assign o_full   = (r_level == LVL_FULL);
  assign o_empty  = (r_level == '0);
  assign o_afull  = (r_level >= LVL_AFULL);
  assign o_wready = !o_full;
  assign o_asend  = !o_empty;
  assign o_adata  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_push = i_wvalid && o_wready;
  assign w_pop  = o_asend && i_aready;

  always_ff @(posedge i_aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge i_aclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + ONE;
        2'b01:   r_level <= r_level - ONE;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef CDC_MCP_TX_FIFO_STATS_EN
  // Statistics survive a flush; only reset or an explicit clear zeroes them.
  logic [31:0] r_sent_count;
  logic        r_push_blocked;

  assign o_sent_count   = r_sent_count;
  assign o_push_blocked = r_push_blocked;

  always_ff @(posedge i_aclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sent_count   <= '0;
      r_push_blocked <= 1'b0;
    end else if (i_stats_clr) begin
      r_sent_count   <= '0;
      r_push_blocked <= 1'b0;
    end else begin
      if (w_pop) r_sent_count <= r_sent_count + 32'd1;
      if (i_wvalid && !o_wready) r_push_blocked <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cdc_mcp_tx_fifo.sv
// Directed bench for cdc_mcp_tx_fifo: expected words queued at stimulus, checked by a pop monitor.
module tb_cdc_mcp_tx_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, wvalid, aready;
  logic [DW-1:0] wdata;
  logic          wready, asend, full, empty, afull;
  logic [DW-1:0] adata;
  logic [LW-1:0] level;
`ifdef CDC_MCP_TX_FIFO_STATS_EN
  logic          stats_clr;
  logic [31:0]   sent_count;
  logic          push_blocked;
`endif

  int checks = 0;
  int errors = 0;
  int m_level = 0;
  int pops = 0;
  logic [DW-1:0] exp_q [$];

  cdc_mcp_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(DEPTH-2)) dut (
    .i_aclk(clk), .i_arst_n(rst_n), .i_flush(flush), .i_wvalid(wvalid), .o_wready(wready),
    .i_wdata(wdata), .o_asend(asend), .o_adata(adata), .i_aready(aready), .o_level(level),
    .o_full(full), .o_empty(empty), .o_afull(afull)
`ifdef CDC_MCP_TX_FIFO_STATS_EN
    , .i_stats_clr(stats_clr), .o_sent_count(sent_count), .o_push_blocked(push_blocked)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop handshake is visible between edges; compare the head word then.
  always @(negedge clk) begin
    if (rst_n && asend && aready) begin
      pops++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", adata);
      end else begin
        if (adata !== exp_q[0]) begin
          errors++;
          $display("FAIL pop_data actual=%0h required=%0h", adata, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_flags(input string tag);
    chk({tag, "_level"},  DW'(level),  DW'(m_level));
    chk({tag, "_empty"},  DW'(empty),  DW'(m_level == 0));
    chk({tag, "_full"},   DW'(full),   DW'(m_level == DEPTH));
    chk({tag, "_wready"}, DW'(wready), DW'(m_level != DEPTH));
    chk({tag, "_asend"},  DW'(asend),  DW'(m_level != 0));
    chk({tag, "_afull"},  DW'(afull),  DW'(m_level >= DEPTH - 2));
  endtask

  // One clock of stimulus; called #1 after an active edge, returns #1 after the next.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic ar, input logic fl);
    bit p, q;
    wvalid = wv; wdata = wd; aready = ar; flush = fl;
    p = wv && (m_level < DEPTH);
    q = ar && (m_level > 0);
    if (p && !fl) exp_q.push_back(wd);
    @(posedge clk); #1;
    if (fl) begin
      m_level = 0;
      exp_q.delete();
    end else begin
      m_level = m_level + int'(p) - int'(q);
    end
    wvalid = 1'b0; aready = 1'b0; flush = 1'b0;
    check_flags("step");
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wvalid = 1'b0; aready = 1'b0; wdata = '0;
`ifdef CDC_MCP_TX_FIFO_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_flags("idle");

    // Fill with aready low; almost-full at 6, full at 8, ninth push refused.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'hA0 + DW'(i), 1'b0, 1'b0);
      chk("fill_level", DW'(level), DW'(i + 1));
      if (i == 4) chk("afull_at5", DW'(afull), 0);
      if (i == 5) chk("afull_at6", DW'(afull), 1);
    end
    chk("full_after8", DW'(full), 1);
    step(1'b1, 32'hA8, 1'b0, 1'b0);
    chk("refused_level", DW'(level), 8);

    // Drain with one ready pulse every four cycles.
    for (int i = 0; i < 8; i++) begin
      chk("drain_head", adata, 32'hA0 + DW'(i));
      step(1'b0, '0, 1'b1, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    end
    chk("drain_empty", DW'(empty), 1);
    chk("drain_pops", DW'(pops), 8);

    // Continuous streaming through pointer wrap.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      chk("stream_level", DW'(level), 1);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_pops", DW'(pops), 28);

    // Flush at level 5 alongside a push and a pop.
    for (int i = 0; i < 5; i++) step(1'b1, 32'hC0 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'hC5, 1'b1, 1'b1);
    chk("flush_level", DW'(level), 0);
    chk("flush_empty", DW'(empty), 1);
    step(1'b1, 32'h55, 1'b0, 1'b0);
    chk("post_flush_asend", DW'(asend), 1);
    chk("post_flush_data", adata, 32'h55);
    step(1'b0, '0, 1'b1, 1'b0);

`ifdef CDC_MCP_TX_FIFO_STATS_EN
    stats_clr = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    stats_clr = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 32'hB0 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'hB8, 1'b0, 1'b0);
    step(1'b1, 32'hB9, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("stats_sent", sent_count, 3);
    chk("stats_blocked", DW'(push_blocked), 1);
    stats_clr = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    stats_clr = 1'b0;
    chk("stats_clr_sent", sent_count, 0);
    chk("stats_clr_blocked", DW'(push_blocked), 0);
`endif

    // Asynchronous reset mid-burst at level 4.
    for (int g = 0; g < 20 && m_level != 4; g++) begin
      if (m_level < 4) step(1'b1, 32'hD0 + DW'(g), 1'b0, 1'b0);
      else step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("pre_reset_level", DW'(level), 4);
    #2 rst_n = 1'b0;
    #1;
    m_level = 0;
    exp_q.delete();
    check_flags("async_reset");
`ifdef CDC_MCP_TX_FIFO_STATS_EN
    chk("reset_sent", sent_count, 0);
    chk("reset_blocked", DW'(push_blocked), 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h77, 1'b0, 1'b0);
    chk("after_reset_data", adata, 32'h77);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("queue_drained", DW'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
